// File: rtl/guess_game_n_pkg.sv
// ============================================================================
// guess_pkg : shared types and helpers for the guess_game_n core
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

package guess_pkg;

  typedef enum logic [1:0] {
    S_SWEEP = 2'd0,
    S_WIN   = 2'd1,
    S_LOSE  = 2'd2
  } state_t;

  localparam int MODE_WRAP   = 0;
  localparam int MODE_BOUNCE = 1;

  // Lose display: every position lit except the two ends.
  function automatic logic [15:0] lose_pattern(input int n);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 16; i++) begin
      p[i] = (i >= 1) && (i <= n - 2);
    end
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/guess_game_n_if.sv
// ============================================================================
// guess_game_n_if : strobe, button and display bundle for guess_game_n
// Revision        : 1.0 - initial release
// ============================================================================
`default_nettype none

interface guess_game_n_if #(
  parameter int N       = 4,
  parameter int SCORE_W = 4
);
  logic               en;
  logic [N-1:0]       b;
  logic [N-1:0]       y;
  logic               win;
  logic               lose;
  logic [SCORE_W-1:0] win_count;
  logic [SCORE_W-1:0] loss_count;

  modport master (
    output en, b,
    input  y, win, lose, win_count, loss_count
  );

  modport slave (
    input  en, b,
    output y, win, lose, win_count, loss_count
  );
endinterface

`default_nettype wire

// File: rtl/guess_game_n_sat_counter.sv
// ============================================================================
// sat_counter : W-bit up counter that sticks at all ones
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

`default_nettype wire

// File: rtl/guess_game_n.sv
// ============================================================================
// guess_game_n : N-position sweep/guess game with win/lose displays and tallies
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

module guess_game_n
  import guess_pkg::*;
#(
  parameter int N       = 4,
  parameter int DIV     = 1,
  parameter int BOUNCE  = 0,
  parameter int SCORE_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  guess_game_n_if.slave  bus
);

  localparam int IDX_W  = $clog2(N);
  localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [IDX_W-1:0]  C_IDX_LAST  = IDX_W'(N - 1);
  localparam logic [TICK_W-1:0] C_TICK_LAST = TICK_W'(DIV - 1);
  localparam logic [15:0]       C_LOSE_FULL = lose_pattern(N);

  state_t              st_q,   st_d;
  logic [IDX_W-1:0]    idx_q,  idx_d;
  logic                dir_q,  dir_d;
  logic [TICK_W-1:0]   tick_q, tick_d;

  logic                win_inc;
  logic                loss_inc;
  logic [N-1:0]        w_onehot;
  logic [N-1:0]        w_lose_pat;
  logic [N-1:0]        y_o;
  logic                win_o;
  logic                lose_o;
  logic [SCORE_W-1:0]  win_cnt;
  logic [SCORE_W-1:0]  loss_cnt;

  assign w_onehot   = {{(N-1){1'b0}}, 1'b1} << idx_q;
  assign w_lose_pat = C_LOSE_FULL[N-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q   <= S_SWEEP;
      idx_q  <= '0;
      dir_q  <= 1'b1;
      tick_q <= '0;
    end else begin
      st_q   <= st_d;
      idx_q  <= idx_d;
      dir_q  <= dir_d;
      tick_q <= tick_d;
    end
  end

  always_comb begin
    st_d     = st_q;
    idx_d    = idx_q;
    dir_d    = dir_q;
    tick_d   = tick_q;
    win_inc  = 1'b0;
    loss_inc = 1'b0;

    if (bus.en) begin
      case (st_q)
        S_SWEEP: begin
          // Any button other than the lit one loses, even alongside the lit one.
          if ((bus.b & ~w_onehot) != '0) begin
            st_d     = S_LOSE;
            loss_inc = 1'b1;
          end else if (bus.b == w_onehot) begin
            st_d    = S_WIN;
            win_inc = 1'b1;
          end else if (tick_q != C_TICK_LAST) begin
            tick_d = tick_q + TICK_W'(1);
          end else begin
            tick_d = '0;
            if (BOUNCE == MODE_WRAP) begin
              idx_d = (idx_q == C_IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end else if (dir_q) begin
              // Flip on arrival at an end so each end is lit for exactly one step.
              idx_d = idx_q + IDX_W'(1);
              if ((idx_q + IDX_W'(1)) == C_IDX_LAST) begin
                dir_d = 1'b0;
              end
            end else begin
              idx_d = idx_q - IDX_W'(1);
              if (idx_q == IDX_W'(1)) begin
                dir_d = 1'b1;
              end
            end
          end
        end

        S_WIN, S_LOSE: begin
          if (bus.b == '0) begin
            st_d   = S_SWEEP;
            idx_d  = '0;
            dir_d  = 1'b1;
            tick_d = '0;
          end
        end

        default: begin
          st_d   = S_SWEEP;
          idx_d  = '0;
          dir_d  = 1'b1;
          tick_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    y_o    = w_onehot;
    win_o  = 1'b0;
    lose_o = 1'b0;
    case (st_q)
      S_WIN: begin
        y_o   = '1;
        win_o = 1'b1;
      end
      S_LOSE: begin
        y_o    = w_lose_pat;
        lose_o = 1'b1;
      end
      default: begin
        y_o = w_onehot;
      end
    endcase
  end

  sat_counter #(.W(SCORE_W)) u_win_count (
    .clk   (clk),
    .reset (reset),
    .inc   (win_inc),
    .q     (win_cnt)
  );

  sat_counter #(.W(SCORE_W)) u_loss_count (
    .clk   (clk),
    .reset (reset),
    .inc   (loss_inc),
    .q     (loss_cnt)
  );

  assign bus.y          = y_o;
  assign bus.win        = win_o;
  assign bus.lose       = lose_o;
  assign bus.win_count  = win_cnt;
  assign bus.loss_count = loss_cnt;

endmodule

`default_nettype wire

// File: tb/tb_guess_game_n.sv
// ============================================================================
// tb_guess_game_n : three game configurations driven by one stimulus stream
// Revision        : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_guess_game_n;

  localparam int N = 4;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       en    = 1'b0;
  logic [3:0] b     = 4'b0000;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Instance A: wrap DIV=2; B: bounce DIV=1 SCORE_W=2; C: bounce DIV=3 SCORE_W=3
  guess_game_n_if #(.N(N), .SCORE_W(4)) if_a ();
  guess_game_n_if #(.N(N), .SCORE_W(2)) if_b ();
  guess_game_n_if #(.N(N), .SCORE_W(3)) if_c ();

  assign if_a.en = en;  assign if_a.b = b;
  assign if_b.en = en;  assign if_b.b = b;
  assign if_c.en = en;  assign if_c.b = b;

  guess_game_n #(.N(N), .DIV(2), .BOUNCE(0), .SCORE_W(4)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a)
  );
  guess_game_n #(.N(N), .DIV(1), .BOUNCE(1), .SCORE_W(2)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b)
  );
  guess_game_n #(.N(N), .DIV(3), .BOUNCE(1), .SCORE_W(3)) dut_c (
    .clk(clk), .reset(reset), .bus(if_c)
  );

  // Reference model: position derived from a count of completed sweep steps.
  int div_k [3] = '{2, 1, 3};
  int bnc_k [3] = '{0, 1, 1};
  int smax  [3] = '{15, 3, 7};
  int m_mode   [3];   // 0 playing, 1 win shown, 2 lose shown
  int m_steps  [3];
  int m_tick   [3];
  int m_wins   [3];
  int m_losses [3];

  function automatic int pos_of(int k);
    int period;
    int p;
    period = (bnc_k[k] != 0) ? 2 * (N - 1) : N;
    p = m_steps[k] % period;
    return (p < N) ? p : period - p;
  endfunction

  function automatic logic [13:0] expv(int k);
    logic [3:0] yy;
    logic       w;
    logic       l;
    yy = 4'(1 << pos_of(k));
    w  = 1'b0;
    l  = 1'b0;
    if (m_mode[k] == 1) begin
      yy = 4'((1 << N) - 1);
      w  = 1'b1;
    end else if (m_mode[k] == 2) begin
      yy = 4'(((1 << N) - 1) & ~1 & ~(1 << (N - 1)));
      l  = 1'b1;
    end
    return {yy, w, l, 4'(m_wins[k]), 4'(m_losses[k])};
  endfunction

  function automatic logic [13:0] obs(int k);
    case (k)
      0:       return {if_a.y, if_a.win, if_a.lose, if_a.win_count, if_a.loss_count};
      1:       return {if_b.y, if_b.win, if_b.lose, 2'b00, if_b.win_count, 2'b00, if_b.loss_count};
      default: return {if_c.y, if_c.win, if_c.lose, 1'b0, if_c.win_count, 1'b0, if_c.loss_count};
    endcase
  endfunction

  function automatic void model_clock(logic r, logic e, logic [3:0] bb);
    int lit;
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        m_mode[k] = 0; m_steps[k] = 0; m_tick[k] = 0;
        m_wins[k] = 0; m_losses[k] = 0;
      end else if (e) begin
        if (m_mode[k] == 0) begin
          lit = 1 << pos_of(k);
          if ((int'(bb) & ~lit) != 0) begin
            m_mode[k] = 2;
            if (m_losses[k] < smax[k]) m_losses[k]++;
          end else if (int'(bb) == lit) begin
            m_mode[k] = 1;
            if (m_wins[k] < smax[k]) m_wins[k]++;
          end else begin
            m_tick[k]++;
            if (m_tick[k] == div_k[k]) begin
              m_tick[k] = 0;
              m_steps[k]++;
            end
          end
        end else if (bb == 4'b0000) begin
          m_mode[k] = 0; m_steps[k] = 0; m_tick[k] = 0;
        end
      end
    end
  endfunction

  task automatic cycle(input logic r, input logic e, input logic [3:0] bb);
    reset = r;
    en    = e;
    b     = bb;
    @(posedge clk);
    model_clock(r, e, bb);
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, 4'b0101);
    n_checks++;
    if ({if_a.y, if_a.win, if_a.lose, if_a.win_count, if_a.loss_count} !== {4'b0001, 2'b00, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_a: got %h want %h",
               {if_a.y, if_a.win, if_a.lose, if_a.win_count, if_a.loss_count}, {4'b0001, 2'b00, 8'h00});
    end
    n_checks++;
    if ({if_b.y, if_b.win, if_b.lose, if_b.win_count, if_b.loss_count} !== {4'b0001, 2'b00, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_b: got %h want %h",
               {if_b.y, if_b.win, if_b.lose, if_b.win_count, if_b.loss_count}, {4'b0001, 2'b00, 4'h0});
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (obs(k) !== expv(k)) begin
        n_fail++;
        $display("FAIL reset_model inst %0d: got %h want %h", k, obs(k), expv(k));
      end
    end
  endtask

  task automatic test_sweep();
    logic [3:0] ea [8] = '{4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
    logic [3:0] eb [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100};
    cycle(1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 4'b0000);
      n_checks++;
      if (if_a.y !== ea[i]) begin
        n_fail++;
        $display("FAIL wrap_seq step %0d: got %b want %b", i, if_a.y, ea[i]);
      end
      n_checks++;
      if (if_b.y !== eb[i]) begin
        n_fail++;
        $display("FAIL bounce_seq step %0d: got %b want %b", i, if_b.y, eb[i]);
      end
      n_checks++;
      if (obs(2) !== expv(2)) begin
        n_fail++;
        $display("FAIL sweep_model_c step %0d: got %h want %h", i, obs(2), expv(2));
      end
    end
  endtask

  task automatic test_correct_press();
    cycle(1'b1, 1'b0, 4'b0000);
    repeat (4) cycle(1'b0, 1'b1, 4'b0000);
    n_checks++;
    if (if_a.y !== 4'b0100) begin
      n_fail++;
      $display("FAIL press_setup: got %b want %b", if_a.y, 4'b0100);
    end
    for (int i = 0; i < 5; i++) begin
      // press, hold three strobes, one idle cycle without a strobe
      cycle(1'b0, (i != 4), (i != 4) ? 4'b0100 : 4'b0000);
      n_checks++;
      if ({if_a.y, if_a.win, if_a.lose, if_a.win_count} !== {4'b1111, 2'b10, 4'd1}) begin
        n_fail++;
        $display("FAIL win_hold %0d: got %h want %h", i,
                 {if_a.y, if_a.win, if_a.lose, if_a.win_count}, {4'b1111, 2'b10, 4'd1});
      end
      for (int k = 1; k < 3; k++) begin
        n_checks++;
        if (obs(k) !== expv(k)) begin
          n_fail++;
          $display("FAIL press_model inst %0d: got %h want %h", k, obs(k), expv(k));
        end
      end
    end
    cycle(1'b0, 1'b1, 4'b0000);
    n_checks++;
    if ({if_a.y, if_a.win, if_a.win_count} !== {4'b0001, 1'b0, 4'd1}) begin
      n_fail++;
      $display("FAIL win_release: got %h want %h", {if_a.y, if_a.win, if_a.win_count}, {4'b0001, 1'b0, 4'd1});
    end
  endtask

  task automatic test_wrong_press();
    logic [3:0] er [3] = '{4'b0001, 4'b0001, 4'b0010};
    cycle(1'b1, 1'b0, 4'b0000);
    repeat (2) cycle(1'b0, 1'b1, 4'b0000);
    cycle(1'b0, 1'b1, 4'b0011);
    n_checks++;
    if ({if_a.y, if_a.win, if_a.lose, if_a.loss_count, if_a.win_count} !== {4'b0110, 2'b01, 4'd1, 4'd0}) begin
      n_fail++;
      $display("FAIL wrong_press: got %h want %h",
               {if_a.y, if_a.win, if_a.lose, if_a.loss_count, if_a.win_count}, {4'b0110, 2'b01, 4'd1, 4'd0});
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 4'b0000);
      n_checks++;
      if ({if_a.y, if_a.lose} !== {er[i], 1'b0}) begin
        n_fail++;
        $display("FAIL lose_release %0d: got %h want %h", i, {if_a.y, if_a.lose}, {er[i], 1'b0});
      end
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (obs(k) !== expv(k)) begin
        n_fail++;
        $display("FAIL wrong_model inst %0d: got %h want %h", k, obs(k), expv(k));
      end
    end
  endtask

  task automatic test_saturation();
    cycle(1'b1, 1'b0, 4'b0000);
    repeat (5) begin
      cycle(1'b0, 1'b1, 4'b0001);
      cycle(1'b0, 1'b1, 4'b0000);
    end
    n_checks++;
    if ({if_b.win_count, if_a.win_count, if_c.win_count} !== {2'd3, 4'd5, 3'd5}) begin
      n_fail++;
      $display("FAIL win_saturate: got %h want %h",
               {if_b.win_count, if_a.win_count, if_c.win_count}, {2'd3, 4'd5, 3'd5});
    end
    cycle(1'b0, 1'b1, 4'b0001);
    n_checks++;
    if ({if_b.y, if_b.win, if_b.win_count} !== {4'b1111, 1'b1, 2'd3}) begin
      n_fail++;
      $display("FAIL win_at_max: got %h want %h", {if_b.y, if_b.win, if_b.win_count}, {4'b1111, 1'b1, 2'd3});
    end
    cycle(1'b1, 1'b1, 4'b0001);
    n_checks++;
    if ({if_b.y, if_b.win, if_b.win_count} !== {4'b0001, 1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_in_win: got %h want %h", {if_b.y, if_b.win, if_b.win_count}, {4'b0001, 1'b0, 2'd0});
    end
  endtask

  task automatic test_random();
    logic       r;
    logic       e;
    logic [3:0] bb;
    int         sel;
    cycle(1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 1500; i++) begin
      r   = ($urandom_range(0, 99) == 0);
      e   = ($urandom_range(0, 2) != 0);
      sel = $urandom_range(0, 9);
      if (sel < 6)      bb = 4'b0000;
      else if (sel < 8) bb = 4'(1 << $urandom_range(0, 3));
      else              bb = 4'($urandom_range(0, 15));
      cycle(r, e, bb);
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (obs(k) !== expv(k)) begin
          n_fail++;
          $display("FAIL random inst %0d cycle %0d: got %h want %h", k, i, obs(k), expv(k));
        end
      end
    end
  endtask

  initial begin
    model_clock(1'b1, 1'b0, 4'b0000);
    repeat (2) cycle(1'b1, 1'b0, 4'b0000);
    test_reset();
    test_sweep();
    test_correct_press();
    test_wrong_press();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/guess_game_n.md
# guess_game_n

Parametrised N-position reaction/guessing game core. A one-hot lit position sweeps across N outputs, and the player presses the button matching the lit position. A correct press enters a win display, and any wrong press enters a lose display. The block adds a configurable sweep rate, wrap or bounce sweep modes, and saturating win/loss tallies. It sits between the debounced button inputs and the LED/seven-segment display logic, and is clocked by the system clock with a game-rate enable strobe.

## Interface
- N, 4: number of positions/buttons; legal range 3..16.
- DIV, 1: number of `en` strobes per sweep step; legal range 1..255.
- BOUNCE, 0: 0 = wrap sweep (N-1 → 0); 1 = ping-pong sweep (…N-2, N-1, N-2…1, 0, 1…).
- SCORE_W, 4: width of the win and loss tallies.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  reset, synchronous, active-high.
- en  in  1  game-rate strobe; one clk wide, arbitrary spacing.
- b  in  N  debounced buttons, one per position; b[i] pairs with y[i].
- y  out  N  display pattern.
- win  out  1  high while in the win display.
- lose  out  1  high while in the lose display.
- win_count  out  SCORE_W  saturating count of wins.
- loss_count  out  SCORE_W  saturating count of losses.

## Operation
- State is held in `st`, with values S_SWEEP, S_WIN and S_LOSE.
- Internal registers:
  - idx: current position, $clog2(N) bits.
  - dir: sweep direction, 1 = up.
  - tick: `en` counter, 0..DIV-1.
- All register updates, except reset, occur only on cycles where en=1.
- Outputs are Moore, decoded combinationally from the registers:
  - S_SWEEP: y = one-hot(idx), win=0, lose=0.
  - S_WIN: y = all ones, win=1, lose=0.
  - S_LOSE: y has bits 1..N-2 set and bits 0 and N-1 clear (0110 for N=4); win=0, lose=1.
- On an en cycle in S_SWEEP, evaluate in priority order:
  - Wrong press: any b[j]=1 with j≠idx → S_LOSE; loss_count increments. This applies even if b[idx] is also set.
  - Correct press: b == one-hot(idx) → S_WIN; win_count increments.
  - No press: b == 0 → tick increments. When tick == DIV-1, tick clears and idx steps:
    - Wrap mode: idx+1, wrapping N-1 → 0.
    - Bounce mode: idx moves in direction dir. dir flips when idx reaches N-1 (going up) or 0 (going down), so end positions are lit for one step each, with no double dwell.
- On an en cycle in S_WIN or S_LOSE:
  - b ≠ 0: remain in the current state (the player must release all buttons).
  - b == 0: go to S_SWEEP with idx=0, dir=1, tick=0.
- Tallies saturate at 2^SCORE_W-1. They are cleared only by reset.
- Button sampling happens only on en cycles. Presses that begin and end between strobes are ignored.

## Timing
- Reset values: st=S_SWEEP, idx=0, dir=1, tick=0, counters=0. Outputs after reset: y=one-hot(0), win=0, lose=0, win_count=0, loss_count=0.
- Reset has priority over en on the same cycle. Reset during a win or lose display returns to S_SWEEP in the next cycle, and the tallies are cleared.
- Latency:
  - A qualifying en edge changes y/win/lose in the following cycle, with no additional pipeline.
  - The tally updates on the same clock edge as the state change.
- The first sweep step after reset or round restart occurs on the DIV-th `en` strobe with b=0.
- en held high continuously is legal: one evaluation occurs per clk.

## Structure
- Package `guess_pkg` holds:
  - The `state_t` enum: S_SWEEP, S_WIN, S_LOSE.
  - Localparam constants for the mode encodings, MODE_WRAP=0 and MODE_BOUNCE=1.
  - A function `lose_pattern(N)` returning the lose-display vector.
- Sub-module `sat_counter` (parameter W; ports clk, reset, inc, q) is instantiated twice, once for each tally.
- The FSM, the index/direction logic and the tick divider live in guess_game_n.

## Test plan
- **Reset:** N=4, assert reset with en=1 → next cycle y=0001, win=0, lose=0, counters 0.
- **Wrap sweep:** N=4, DIV=2, b=0, en every cycle → y holds each value for 2 cycles in the sequence 0001, 0010, 0100, 1000, 0001.
- **Bounce sweep:** N=4, BOUNCE=1, DIV=1 → y sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010.
- **Correct press and release:**
  - At y=0100, b=0100 on en → y=1111, win=1, win_count=1.
  - Hold b for 3 strobes → state is unchanged.
  - b=0 on en → y=0001.
- **Wrong press priority:**
  - At y=0010, b=0011 on en → y=0110, lose=1, loss_count=1.
  - Release → y=0001, with idx restarted at 0.
- **Saturation and mid-game reset:**
  - SCORE_W=2, play 5 wins → win_count=3.
  - Assert reset while in S_WIN → next cycle y=0001, win=0, win_count=0.
